// File: rtl/config_pkg.sv
// Shared core configuration: datapath widths and the LSU operation encoding.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{XLEN: 64, PLEN: 40};

    typedef enum logic [3:0] {
        LsuLb, LsuLh, LsuLw, LsuLd, LsuLbu, LsuLhu, LsuLwu,
        LsuSb, LsuSh, LsuSw, LsuSd
    } lsu_op_e;

    // Access size in bytes for both load and store encodings.
    function automatic logic [3:0] op_size(lsu_op_e op);
        case (op)
            LsuLb, LsuLbu, LsuSb: return 4'd1;
            LsuLh, LsuLhu, LsuSh: return 4'd2;
            LsuLw, LsuLwu, LsuSw: return 4'd4;
            default:              return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-facing bundle of the store buffer: allocation, fill, commit, forwarding, drain.
interface store_buffer_if #(
    parameter config_pkg::cfg_t Cfg           = config_pkg::EmptyCfg,
    parameter int unsigned      SB_IDX_WIDTH  = 4,
    parameter int unsigned      ROB_IDX_WIDTH = 6
);
    logic                         flush_i;

    logic                         alloc_valid_i;
    logic                         alloc_ready_o;
    logic [SB_IDX_WIDTH-1:0]      alloc_id_o;

    logic                         ex_valid_i;
    logic [SB_IDX_WIDTH-1:0]      ex_sb_id_i;
    logic [Cfg.PLEN-1:0]          ex_addr_i;
    logic [Cfg.XLEN-1:0]          ex_data_i;
    config_pkg::lsu_op_e          ex_op_i;
    logic [ROB_IDX_WIDTH-1:0]     ex_rob_idx_i;

    logic                         commit_valid_i;
    logic [ROB_IDX_WIDTH-1:0]     rob_head_i;

    logic [Cfg.PLEN-1:0]          load_addr_i;
    logic [ROB_IDX_WIDTH-1:0]     load_rob_idx_i;
    config_pkg::lsu_op_e          load_op_i;
    logic                         load_hit_o;
    logic [Cfg.XLEN-1:0]          load_data_o;

    logic                         dc_req_valid_o;
    logic                         dc_req_ready_i;
    logic [Cfg.PLEN-1:0]          dc_req_addr_o;
    logic [Cfg.XLEN-1:0]          dc_req_data_o;
    config_pkg::lsu_op_e          dc_req_op_o;

    logic                         empty_o;

    modport slave (
        input  flush_i, alloc_valid_i, ex_valid_i, ex_sb_id_i, ex_addr_i, ex_data_i, ex_op_i,
               ex_rob_idx_i, commit_valid_i, rob_head_i, load_addr_i, load_rob_idx_i,
               load_op_i, dc_req_ready_i,
        output alloc_ready_o, alloc_id_o, load_hit_o, load_data_o, dc_req_valid_o,
               dc_req_addr_o, dc_req_data_o, dc_req_op_o, empty_o
    );

    modport master (
        output flush_i, alloc_valid_i, ex_valid_i, ex_sb_id_i, ex_addr_i, ex_data_i, ex_op_i,
               ex_rob_idx_i, commit_valid_i, rob_head_i, load_addr_i, load_rob_idx_i,
               load_op_i, dc_req_ready_i,
        input  alloc_ready_o, alloc_id_o, load_hit_o, load_data_o, dc_req_valid_o,
               dc_req_addr_o, dc_req_data_o, dc_req_op_o, empty_o
    );

endinterface

// File: rtl/store_buffer.sv
// Circular store buffer: in-order allocation, out-of-order fill, in-order commit and
// D-cache drain, with store-to-load forwarding from older filled or committed stores.
module store_buffer #(
    parameter config_pkg::cfg_t Cfg           = config_pkg::EmptyCfg,
    parameter int unsigned      SB_DEPTH      = 16,
    parameter int unsigned      SB_IDX_WIDTH  = $clog2(SB_DEPTH),
    parameter int unsigned      ROB_IDX_WIDTH = 6
) (
    input logic           clk_i,
    input logic           rst_i,
    store_buffer_if.slave sb
);
    localparam int unsigned XLEN = Cfg.XLEN;
    localparam int unsigned PLEN = Cfg.PLEN;

    localparam logic [1:0] StFree      = 2'd0;
    localparam logic [1:0] StAlloc     = 2'd1;
    localparam logic [1:0] StFilled    = 2'd2;
    localparam logic [1:0] StCommitted = 2'd3;

    typedef logic [SB_IDX_WIDTH-1:0]  idx_t;
    typedef logic [SB_IDX_WIDTH:0]    cnt_t;
    typedef logic [ROB_IDX_WIDTH-1:0] rob_t;

    localparam cnt_t DepthCnt = cnt_t'(SB_DEPTH);

    logic [1:0]          state_q [SB_DEPTH];
    logic [1:0]          state_d [SB_DEPTH];
    logic [PLEN-1:0]     addr_q  [SB_DEPTH];
    logic [XLEN-1:0]     data_q  [SB_DEPTH];
    config_pkg::lsu_op_e op_q    [SB_DEPTH];
    rob_t                rob_q   [SB_DEPTH];

    idx_t head_q, head_d;
    idx_t cptr_q, cptr_d;
    idx_t tail_q, tail_d;
    cnt_t count_q, count_d;
    cnt_t ccnt_q, ccnt_d;  // committed-but-not-drained entries

    logic alloc_fire, fill_fire, commit_fire, drain_fire;

    assign sb.alloc_ready_o  = (count_q < DepthCnt) && !sb.flush_i;
    assign sb.alloc_id_o     = tail_q;
    assign sb.empty_o        = (count_q == '0);

    assign sb.dc_req_valid_o = (state_q[head_q] == StCommitted);
    assign sb.dc_req_addr_o  = addr_q[head_q];
    assign sb.dc_req_data_o  = data_q[head_q];
    assign sb.dc_req_op_o    = op_q[head_q];

    assign alloc_fire  = sb.alloc_valid_i && sb.alloc_ready_o;
    assign fill_fire   = sb.ex_valid_i && !sb.flush_i && (state_q[sb.ex_sb_id_i] == StAlloc);
    assign commit_fire = sb.commit_valid_i && (ccnt_q < count_q);
    assign drain_fire  = sb.dc_req_valid_o && sb.dc_req_ready_i;

    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            state_d[i] = state_q[i];
        end
        if (drain_fire) state_d[head_q] = StFree;
        if (fill_fire) state_d[sb.ex_sb_id_i] = StFilled;
        if (commit_fire) state_d[cptr_q] = StCommitted;
        if (alloc_fire) state_d[tail_q] = StAlloc;
        // Commit has already been folded in, so only speculative entries are dropped.
        if (sb.flush_i) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (state_d[i] == StAlloc || state_d[i] == StFilled) state_d[i] = StFree;
            end
        end
    end

    always_comb begin
        head_d  = drain_fire ? head_q + idx_t'(1) : head_q;
        cptr_d  = commit_fire ? cptr_q + idx_t'(1) : cptr_q;
        tail_d  = alloc_fire ? tail_q + idx_t'(1) : tail_q;

        count_d = count_q;
        if (alloc_fire && !drain_fire) begin
            count_d = count_q + cnt_t'(1);
        end else if (!alloc_fire && drain_fire) begin
            count_d = count_q - cnt_t'(1);
        end

        ccnt_d = ccnt_q;
        if (commit_fire && !drain_fire) begin
            ccnt_d = ccnt_q + cnt_t'(1);
        end else if (!commit_fire && drain_fire) begin
            ccnt_d = ccnt_q - cnt_t'(1);
        end

        if (sb.flush_i) begin
            tail_d  = cptr_d;
            count_d = ccnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                state_q[i] <= StFree;
            end
            head_q  <= '0;
            cptr_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ccnt_q  <= '0;
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                state_q[i] <= state_d[i];
            end
            head_q  <= head_d;
            cptr_q  <= cptr_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ccnt_q  <= ccnt_d;
        end
    end

    // Payload is only meaningful once the state says FILLED, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (fill_fire) begin
            addr_q[sb.ex_sb_id_i] <= sb.ex_addr_i;
            data_q[sb.ex_sb_id_i] <= sb.ex_data_i;
            op_q[sb.ex_sb_id_i]   <= sb.ex_op_i;
            rob_q[sb.ex_sb_id_i]  <= sb.ex_rob_idx_i;
        end
    end

    // Forwarding: scan oldest to youngest so the last match is the youngest older store.
    logic       match;
    idx_t       match_idx;
    idx_t       e;
    rob_t       load_age;
    rob_t       entry_age;
    logic       cand;
    logic [3:0] st_size;
    logic       fwd_hit;
    logic [XLEN-1:0] fwd_data;

    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        e         = '0;
        entry_age = '0;
        cand      = 1'b0;
        load_age  = sb.load_rob_idx_i - sb.rob_head_i;
        for (int i = 0; i < SB_DEPTH; i++) begin
            e         = head_q + idx_t'(i);
            entry_age = rob_q[e] - sb.rob_head_i;
            cand      = (state_q[e] == StCommitted) ||
                        ((state_q[e] == StFilled) && (entry_age < load_age));
            if (cand && (addr_q[e] == sb.load_addr_i)) begin
                match     = 1'b1;
                match_idx = e;
            end
        end

        st_size  = config_pkg::op_size(op_q[match_idx]);
        fwd_hit  = match && (st_size >= config_pkg::op_size(sb.load_op_i));
        fwd_data = '0;
        if (fwd_hit) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                if (b < int'(st_size)) fwd_data[b*8 +: 8] = data_q[match_idx][b*8 +: 8];
            end
        end
    end

    assign sb.load_hit_o  = fwd_hit;
    assign sb.load_data_o = fwd_data;

    commit_needs_filled: assert property (
        @(posedge clk_i) disable iff (rst_i)
        sb.commit_valid_i |-> (state_q[cptr_q] == StFilled)
    );

endmodule
